// File: rtl/ex_muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// MULT/MULTU use radix-2 shift-add; DIV/DIVU use restoring division on a
// 64-bit {remainder, quotient} register. Each operation keeps busy high for
// 33 cycles (32 RUN steps plus one FIX cycle), and any HI/LO instruction in
// EX stalls the front end while busy.
module ex_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hilo_rdata,
    output logic        div0
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    typedef struct packed {
        logic mult;
        logic multu;
        logic div;
        logic divu;
        logic mfhi;
        logic mflo;
        logic mthi;
        logic mtlo;
    } dec_t;

    state_t      state;
    logic [4:0]  count;
    logic        is_div;
    logic        sign_a;
    logic        sign_b;
    logic        dz;        // divisor was zero at issue
    logic [31:0] opb;       // multiplicand or divisor magnitude
    logic [63:0] acc;       // product, or {remainder, quotient}
    logic [31:0] rs_raw;    // dividend as issued, returned in HI on divide by zero
    logic [31:0] hi;
    logic [31:0] lo;

    dec_t        dec;
    logic        any_hilo;
    logic        is_md;
    logic        issue;
    logic        mt_ok;
    logic        signed_op;
    logic        div_op;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_rem;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Instruction decode of the EX instruction
    always_comb begin
        dec = '0;
        if (op == 6'b000000) begin
            case (funct)
                6'b011000: dec.mult  = 1'b1;
                6'b011001: dec.multu = 1'b1;
                6'b011010: dec.div   = 1'b1;
                6'b011011: dec.divu  = 1'b1;
                6'b010000: dec.mfhi  = 1'b1;
                6'b010010: dec.mflo  = 1'b1;
                6'b010001: dec.mthi  = 1'b1;
                6'b010011: dec.mtlo  = 1'b1;
                default:   dec       = '0;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign any_hilo  = |dec;
    assign is_md     = dec.mult | dec.multu | dec.div | dec.divu;
    assign stall     = ex_valid & ~ex_flush & any_hilo & busy;
    assign issue     = ex_valid & ~ex_flush & ~stall & is_md;
    assign mt_ok     = ex_valid & ~ex_flush & ~stall & (dec.mthi | dec.mtlo);
    assign signed_op = dec.mult | dec.div;
    assign div_op    = dec.div | dec.divu;

    // 0x80000000 negates to itself, which is its correct unsigned magnitude
    assign abs_rs = (signed_op & rs_val[31]) ? -rs_val : rs_val;
    assign abs_rt = (signed_op & rt_val[31]) ? -rt_val : rt_val;

    // One iteration step of each datapath
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        div_rem  = {acc[63:32], acc[31]};
        div_ge   = (div_rem >= {1'b0, opb});
        // true difference is below opb, so a 32-bit subtract is exact
        div_diff = div_rem[31:0] - opb;
        div_next = div_ge ? {div_diff, acc[30:0], 1'b1}
                          : {div_rem[31:0], acc[30:0], 1'b0};
    end

    // Sign fixup applied in FIX
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix  = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
        rem_fix  = sign_a ? -acc[63:32] : acc[63:32];
    end

    // HI/LO read port
    always_comb begin
        hilo_rdata = 32'd0;
        if (dec.mfhi)      hilo_rdata = hi;
        else if (dec.mflo) hilo_rdata = lo;
    end

    // Control FSM with iteration datapath and HI/LO/div0 state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
            opb    <= '0;
            acc    <= '0;
            rs_raw <= '0;
            hi     <= '0;
            lo     <= '0;
            div0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        is_div <= div_op;
                        sign_a <= signed_op & rs_val[31];
                        sign_b <= signed_op & rt_val[31];
                        dz     <= div_op & (rt_val == 32'd0);
                        rs_raw <= rs_val;
                        count  <= '0;
                        if (div_op) begin
                            opb <= abs_rt;
                            acc <= {32'd0, abs_rs};
                        end else begin
                            opb <= abs_rs;
                            acc <= {32'd0, abs_rt};
                        end
                        state <= RUN;
                    end else if (mt_ok) begin
                        if (dec.mthi) hi <= rs_val;
                        if (dec.mtlo) lo <= rs_val;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        if (dz) begin
                            hi   <= rs_raw;
                            lo   <= 32'hFFFF_FFFF;
                            div0 <= 1'b1;
                        end else begin
                            hi   <= rem_fix;
                            lo   <= quo_fix;
                            div0 <= 1'b0;
                        end
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: expected HI/LO/div0 are pushed to a
// scoreboard at issue and popped when the operation completes.
module tb_ex_muldiv_ctrl;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_flush = 1'b0;
    logic [5:0]  op = '0;
    logic [5:0]  funct = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        stall;
    logic        busy;
    logic [31:0] hilo_rdata;
    logic        div0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
    } exp_t;

    exp_t        sb[$];
    int          errs = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_div0 = 1'b0;

    ex_muldiv_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_flush   (ex_flush),
        .op         (op),
        .funct      (funct),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .stall      (stall),
        .busy       (busy),
        .hilo_rdata (hilo_rdata),
        .div0       (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        longint      sa, sbv, p, q, rr;
        logic [63:0] u;
        r = '0;
        r.d0 = m_div0;
        case (f)
            F_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                u = p;
                r.hi = u[63:32]; r.lo = u[31:0];
            end
            F_MULTU: begin
                u = {32'd0, a} * {32'd0, b};
                r.hi = u[63:32]; r.lo = u[31:0];
            end
            F_DIV: begin
                if (b == 32'd0) begin
                    r.hi = a; r.lo = 32'hFFFF_FFFF; r.d0 = 1'b1;
                end else begin
                    sa = longint'($signed(a));
                    sbv = longint'($signed(b));
                    q = sa / sbv;
                    rr = sa % sbv;
                    u = q;  r.lo = u[31:0];
                    u = rr; r.hi = u[31:0];
                    r.d0 = 1'b0;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    r.hi = a; r.lo = 32'hFFFF_FFFF; r.d0 = 1'b1;
                end else begin
                    r.lo = a / b; r.hi = a % b; r.d0 = 1'b0;
                end
            end
        endcase
        return r;
    endfunction

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic fl);
        ex_valid = 1'b1; ex_flush = fl; op = 6'b000000; funct = f; rs_val = a; rt_val = b;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; ex_flush = 1'b0; op = 6'b000000; funct = 6'b000000;
        rs_val = '0; rt_val = '0;
    endtask

    task automatic push(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(f, a, b);
        m_div0 = e.d0;
        sb.push_back(e);
    endtask

    // Present an op while idle, take the issue edge, record its expectation
    task automatic issue(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        drive(f, a, b, 1'b0);
        #1;
        chk({tag, "_issue_stall"}, stall, 0);
        @(posedge clk); #1;
        push(f, a, b);
        idle_in();
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_busy_cycles"}, n, 33);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            m_hi = e.hi; m_lo = e.lo;
            drive(F_MFHI, 0, 0, 1'b0); #1;
            chk({tag, "_hi"}, hilo_rdata, e.hi);
            drive(F_MFLO, 0, 0, 1'b0); #1;
            chk({tag, "_lo"}, hilo_rdata, e.lo);
            chk({tag, "_div0"}, div0, e.d0);
            idle_in();
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        issue(tag, f, a, b);
        wait_busy(tag);
        check_result(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t dump;
        logic [5:0] kinds [4];
        kinds[0] = F_MULT; kinds[1] = F_MULTU; kinds[2] = F_DIV; kinds[3] = F_DIVU;

        // reset state, with an MFHI presented
        idle_in();
        drive(F_MFHI, 0, 0, 1'b0);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_div0", div0, 0);
        chk("rst_rdata_hi", hilo_rdata, 0);
        drive(F_MFLO, 0, 0, 1'b0); #1;
        chk("rst_rdata_lo", hilo_rdata, 0);
        idle_in();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // signed multiply -2 * 3
        run_op("mult_neg", F_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("mult_neg_hi_const", m_hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo_const", m_lo, 32'hFFFF_FFFA);

        // DIVU 100/7 with MFLO as the very next instruction
        issue("divu_mflo", F_DIVU, 32'd100, 32'd7);
        drive(F_MFLO, 0, 0, 1'b0); #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("divu_mflo_stall_cycles", n, 33);
        chk("divu_mflo_rdata", hilo_rdata, 32'd14);
        check_result("divu_mflo");
        chk("divu_mfhi_const", m_hi, 32'd2);

        // signed divides
        run_op("div_neg7", F_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg7_lo_const", m_lo, 32'hFFFF_FFFD);
        chk("div_neg7_hi_const", m_hi, 32'hFFFF_FFFF);
        run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_const", m_lo, 32'h8000_0000);
        chk("div_ovf_hi_const", m_hi, 32'h0000_0000);

        // divide by zero sets div0; MULT keeps it; good divide clears it
        run_op("divu_zero", F_DIVU, 32'h0000_1234, 32'd0);
        chk("divu_zero_div0", div0, 1);
        run_op("mult_keep", F_MULT, 32'h8000_0000, 32'h8000_0000);
        chk("mult_keep_div0", div0, 1);
        run_op("divu_clear", F_DIVU, 32'd9, 32'd3);
        chk("divu_clear_div0", div0, 0);
        run_op("div_zero_signed", F_DIV, 32'hFFFF_FF00, 32'd0);

        // flushed MULTU does nothing
        drive(F_MULTU, 32'd5, 32'd7, 1'b1); #1;
        chk("flush_stall", stall, 0);
        @(posedge clk); #1;
        idle_in(); #1;
        chk("flush_busy", busy, 0);
        drive(F_MFHI, 0, 0, 1'b0); #1;
        chk("flush_hi", hilo_rdata, m_hi);
        drive(F_MFLO, 0, 0, 1'b0); #1;
        chk("flush_lo", hilo_rdata, m_lo);

        // MTHI idle, flushed MTLO ignored, real MTLO
        drive(F_MTHI, 32'hCAFE_F00D, 0, 1'b0);
        @(posedge clk); #1;
        m_hi = 32'hCAFE_F00D;
        drive(F_MTLO, 32'h1111_2222, 0, 1'b1);
        @(posedge clk); #1;
        drive(F_MFHI, 0, 0, 1'b0); #1;
        chk("mthi_rd", hilo_rdata, 32'hCAFE_F00D);
        drive(F_MFLO, 0, 0, 1'b0); #1;
        chk("mtlo_flushed_rd", hilo_rdata, m_lo);
        drive(F_MTLO, 32'h0BAD_BEEF, 0, 1'b0);
        @(posedge clk); #1;
        m_lo = 32'h0BAD_BEEF;
        drive(F_MFLO, 0, 0, 1'b0); #1;
        chk("mtlo_rd", hilo_rdata, 32'h0BAD_BEEF);
        idle_in();

        // back-to-back: second MULTU waits in EX and issues with no bubble
        issue("b2b_first", F_MULT, 32'h0001_0003, 32'hFFFF_0005);
        drive(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0); #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_stall_cycles", n, 33);
        chk("b2b_idle_gap", busy, 0);
        check_result("b2b_first");
        drive(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        @(posedge clk); #1;
        push(F_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
        idle_in();
        wait_busy("b2b_second");
        check_result("b2b_second");

        // random mix
        for (int i = 0; i < 8; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = kinds[$urandom_range(0, 3)];
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 2 == 1) a = {a[31], 31'($urandom_range(0, 100000))};
            run_op($sformatf("rand%0d", i), f, a, b);
        end

        // reset in the middle of RUN discards the operation
        run_op("pre_rst_dz", F_DIVU, 32'd77, 32'd0);
        issue("rst_mid", F_MULT, 32'd12345, 32'd678);
        repeat (15) @(posedge clk);
        #1;
        drive(F_MFHI, 0, 0, 1'b0); #1;
        chk("mid_run_busy", busy, 1);
        chk("mid_run_stall", stall, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_div0", div0, 0);
        chk("mid_rst_hi", hilo_rdata, 0);
        drive(F_MFLO, 0, 0, 1'b0); #1;
        chk("mid_rst_lo", hilo_rdata, 0);
        idle_in();
        dump = sb.pop_back();
        m_hi = '0; m_lo = '0; m_div0 = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", F_MULT, 32'hFFFF_FFF0, 32'h0000_0100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
